rcb_bank: RTL

- Multi-channel RAM control bank replacing per-table single RCB instances inside the strategy block.
- Holds NUM_CH parallel tables (symbol, price, volume, order, ...) that share one tick-to-trade (t2t) read address and one host write port.
- Arbitrates host writes against t2t reads: reads always win; writes are deferred out of message windows, with a bounded-starvation override.
- Adds broadcast writes, out-of-range channel error reporting and configurable read latency.

---
 rtl/rcb_bank_if.sv | 33 +++
 rtl/rcb_bank.sv | 133 +++++++++++++
 2 files changed

// File: rtl/rcb_bank_if.sv
// Bus bundle for rcb_bank: the t2t read port, read data return and the host write handshake.
interface rcb_bank_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 128,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [ADDR_W-1:0]        t2t_rd_addr;
  logic                     t2t_rd_en;
  logic                     t2t_inmsg;
  logic [NUM_CH*DATA_W-1:0] rcb_data;
  logic                     rcb_vld;
  logic [ADDR_W-1:0]        hpb_wr_addr;
  logic [DATA_W-1:0]        hpb_wr_data;
  logic [CH_W-1:0]          hpb_wr_ch;
  logic                     hpb_wr_bcast;
  logic                     hpb_wr_req;
  logic                     hpb_wr_busy;
  logic                     hpb_wr_done;
  logic                     hpb_wr_err;

  modport master (
    output t2t_rd_addr, t2t_rd_en, t2t_inmsg,
    output hpb_wr_addr, hpb_wr_data, hpb_wr_ch, hpb_wr_bcast, hpb_wr_req,
    input  rcb_data, rcb_vld, hpb_wr_busy, hpb_wr_done, hpb_wr_err
  );

  modport slave (
    input  t2t_rd_addr, t2t_rd_en, t2t_inmsg,
    input  hpb_wr_addr, hpb_wr_data, hpb_wr_ch, hpb_wr_bcast, hpb_wr_req,
    output rcb_data, rcb_vld, hpb_wr_busy, hpb_wr_done, hpb_wr_err
  );
endinterface

// File: rtl/rcb_bank.sv
// Bank of NUM_CH single-port tables sharing one t2t read address and one host write port.
// Reads always win; host writes wait for an idle slot outside messages or after starvation.
module rcb_bank #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 128,
  parameter int RD_LATENCY = 1,
  parameter int STARVE_MAX = 16
) (
  input logic        clk,
  input logic        reset,
  rcb_bank_if.slave  bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [CH_W:0] NUM_CH_LIM = (CH_W + 1)'(NUM_CH);
  localparam logic [7:0]    STARVE_LIM = 8'(STARVE_MAX);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [CH_W-1:0]   lat_ch;
  logic              lat_bcast;
  logic              lat_err;
  logic [7:0]        starve_cnt;
  logic              ch_oor;
  logic              slot_ok;
  logic              commit;
  logic              vld1;

  assign ch_oor  = !lat_bcast && ({1'b0, lat_ch} >= NUM_CH_LIM);
  assign slot_ok = !bus.t2t_rd_en && (!bus.t2t_inmsg || (starve_cnt >= STARVE_LIM));
  // Reset gates the RAM write so a pending write in the reset cycle is discarded.
  assign commit  = (state == PEND) && slot_ok && !ch_oor && !reset;

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.hpb_wr_req) begin
      lat_addr  <= bus.hpb_wr_addr;
      lat_data  <= bus.hpb_wr_data;
      lat_ch    <= bus.hpb_wr_ch;
      lat_bcast <= bus.hpb_wr_bcast;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.hpb_wr_req) state <= PEND;
        PEND: begin
          if (ch_oor || slot_ok) begin
            state      <= DONE;
            lat_err    <= ch_oor;
            starve_cnt <= '0;
          end else if (bus.t2t_inmsg && starve_cnt != 8'hFF) begin
            starve_cnt <= starve_cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hpb_wr_busy = (state != IDLE);
  assign bus.hpb_wr_done = (state == DONE);
  assign bus.hpb_wr_err  = (state == DONE) && lat_err;

  always_ff @(posedge clk) begin
    if (reset) vld1 <= 1'b0;
    else       vld1 <= bus.t2t_rd_en;
  end

  if (RD_LATENCY == 2) begin : g_vld2
    logic vld2;
    always_ff @(posedge clk) begin
      if (reset) vld2 <= 1'b0;
      else       vld2 <= vld1;
    end
    assign bus.rcb_vld = vld2;
  end else begin : g_vld1
    assign bus.rcb_vld = vld1;
  end

  logic [DATA_W-1:0]        ch_dout [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] rd_data;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [CH_W:0] IDX = (CH_W + 1)'(k);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic              we;

    assign we = commit && (lat_bcast || ({1'b0, lat_ch} == IDX));

    always_ff @(posedge clk) begin
      if (we) mem[lat_addr] <= lat_data;
    end

    always_ff @(posedge clk) begin
      if (reset)                rd_q <= '0;
      else if (bus.t2t_rd_en)   rd_q <= mem[bus.t2t_rd_addr];
    end

    if (RD_LATENCY == 2) begin : g_oreg
      logic [DATA_W-1:0] out_q;
      always_ff @(posedge clk) begin
        if (reset)     out_q <= '0;
        else if (vld1) out_q <= rd_q;
      end
      assign ch_dout[k] = out_q;
    end else begin : g_noreg
      assign ch_dout[k] = rd_q;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      rd_data[i*DATA_W +: DATA_W] = ch_dout[i];
    end
  end

  assign bus.rcb_data = rd_data;
endmodule
